mem_arbiter: RTL

Two-port round-robin arbiter that shares the single-outstanding memory port between requesters, e.g. `fabric32` and a host/DMA engine. It serialises read and write transactions onto the memory interface (`req_rd`/`req_wr`/`addr_*`/`data_*`/`data_rdy`) and returns read data and a completion strobe to the winning requester. It also aborts hung transactions with a timeout.

---
 rtl/mem_arbiter.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-outstanding memory port.
// Serialises reads/writes, returns completion per port, aborts hung transactions.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic [1:0]  rq_rd,
    input  logic [1:0]  rq_wr,
    input  logic [31:0] rq0_addr_rd,
    input  logic [31:0] rq1_addr_rd,
    input  logic [31:0] rq0_addr_wr,
    input  logic [31:0] rq1_addr_wr,
    input  logic [31:0] rq0_data_wr,
    input  logic [31:0] rq1_data_wr,
    output logic [1:0]  rq_ack,
    output logic        rq_err,
    output logic [31:0] rq_data_rd,
    output logic        busy,
    output logic        grant,
    output logic        req_rd,
    output logic        req_wr,
    output logic [31:0] addr_rd,
    output logic [31:0] addr_wr,
    output logic [31:0] data_wr,
    input  logic [31:0] data_rd,
    input  logic        data_rdy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_LO,
        S_WAIT_HI,
        S_DONE
    } state_t;

    // The counter reads 0 in the first wait cycle, so matching TIMEOUT aborts
    // after TIMEOUT+1 wait cycles and lands the ack TIMEOUT+2 cycles after ISSUE.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT);

    state_t      state_q, state_d;
    logic        grant_q, grant_d;
    logic        last_grant_q, last_grant_d;
    logic        op_rd_q, op_rd_d;
    logic        req_rd_q, req_rd_d;
    logic        req_wr_q, req_wr_d;
    logic [31:0] addr_rd_q, addr_rd_d;
    logic [31:0] addr_wr_q, addr_wr_d;
    logic [31:0] data_wr_q, data_wr_d;
    logic [1:0]  rq_ack_q, rq_ack_d;
    logic        err_q, err_d;
    logic [31:0] rq_data_rd_q, rq_data_rd_d;
    logic        busy_q, busy_d;
    logic [15:0] cnt_q, cnt_d;

    logic [1:0]  pend;
    logic        win;
    logic        timeout_hit;
    logic [1:0]  ack_onehot;

    assign pend        = rq_rd | rq_wr;
    assign win         = (pend == 2'b11) ? ~last_grant_q : pend[1];
    assign timeout_hit = (cnt_q == TMO_LAST);
    assign ack_onehot  = grant_q ? 2'b10 : 2'b01;

    always_comb begin
        // NOTE: every next-state value gets a default before the case statement;
        // a path that leaves one unassigned would infer a latch.
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        op_rd_d      = op_rd_q;
        req_rd_d     = 1'b0;
        req_wr_d     = 1'b0;
        addr_rd_d    = addr_rd_q;
        addr_wr_d    = addr_wr_q;
        data_wr_d    = data_wr_q;
        rq_ack_d     = 2'b00;
        err_d        = err_q;
        rq_data_rd_d = rq_data_rd_q;
        cnt_d        = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (data_rdy && (pend != 2'b00)) begin
                    grant_d = win;
                    op_rd_d = rq_rd[win];
                    if (rq_rd[win]) begin
                        req_rd_d  = 1'b1;
                        addr_rd_d = win ? rq1_addr_rd : rq0_addr_rd;
                    end else begin
                        req_wr_d  = 1'b1;
                        addr_wr_d = win ? rq1_addr_wr : rq0_addr_wr;
                        data_wr_d = win ? rq1_data_wr : rq0_data_wr;
                    end
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                last_grant_d = grant_q;
                cnt_d        = 16'd0;
                state_d      = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                cnt_d = cnt_q + 16'd1;
                if (!data_rdy) begin
                    state_d = S_WAIT_HI;
                end else if (timeout_hit) begin
                    err_d        = 1'b1;
                    rq_data_rd_d = 32'd0;
                    rq_ack_d     = ack_onehot;
                    state_d      = S_DONE;
                end
            end
            S_WAIT_HI: begin
                cnt_d = cnt_q + 16'd1;
                if (data_rdy) begin
                    if (op_rd_q) begin
                        rq_data_rd_d = data_rd;
                    end
                    rq_ack_d = ack_onehot;
                    state_d  = S_DONE;
                end else if (timeout_hit) begin
                    err_d        = 1'b1;
                    rq_data_rd_d = 32'd0;
                    rq_ack_d     = ack_onehot;
                    state_d      = S_DONE;
                end
            end
            S_DONE: begin
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q      <= S_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            op_rd_q      <= 1'b0;
            req_rd_q     <= 1'b0;
            req_wr_q     <= 1'b0;
            addr_rd_q    <= 32'd0;
            addr_wr_q    <= 32'd0;
            data_wr_q    <= 32'd0;
            rq_ack_q     <= 2'b00;
            err_q        <= 1'b0;
            rq_data_rd_q <= 32'd0;
            busy_q       <= 1'b0;
            cnt_q        <= 16'd0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            op_rd_q      <= op_rd_d;
            req_rd_q     <= req_rd_d;
            req_wr_q     <= req_wr_d;
            addr_rd_q    <= addr_rd_d;
            addr_wr_q    <= addr_wr_d;
            data_wr_q    <= data_wr_d;
            rq_ack_q     <= rq_ack_d;
            err_q        <= err_d;
            rq_data_rd_q <= rq_data_rd_d;
            busy_q       <= busy_d;
            cnt_q        <= cnt_d;
        end
    end

    assign rq_ack     = rq_ack_q;
    assign rq_err     = err_q;
    assign rq_data_rd = rq_data_rd_q;
    assign busy       = busy_q;
    assign grant      = grant_q;
    assign req_rd     = req_rd_q;
    assign req_wr     = req_wr_q;
    assign addr_rd    = addr_rd_q;
    assign addr_wr    = addr_wr_q;
    assign data_wr    = data_wr_q;

endmodule
